// File: rtl/vx_warp_ctl_pkg.sv
// Shared GPU control types: request payloads, barrier table entry,
// warp-control FSM states and a lowest-set-bit priority encoder.
package vx_warp_ctl_pkg;

   localparam int NUM_WARPS    = 4;
   localparam int NUM_THREADS  = 4;
   localparam int NUM_BARRIERS = 4;

   localparam int NW_BITS = $clog2(NUM_WARPS);
   localparam int NB_BITS = $clog2(NUM_BARRIERS);
   // Widths clamped to at least one bit so single-warp/single-barrier builds still elaborate.
   localparam int NW_W = (NW_BITS > 0) ? NW_BITS : 1;
   localparam int NB_W = (NB_BITS > 0) ? NB_BITS : 1;

   typedef struct packed {
      logic                   valid;
      logic [NUM_THREADS-1:0] tmask;
   } gpu_tmc_t;

   typedef struct packed {
      logic                 valid;
      logic [NUM_WARPS-1:0] wmask;
      logic [31:0]          pc;
   } gpu_wspawn_t;

   typedef struct packed {
      logic            valid;
      logic [NB_W-1:0] id;
      logic [NW_W-1:0] size_m1;
   } gpu_barrier_t;

   localparam int GPU_TMC_BITS     = $bits(gpu_tmc_t);
   localparam int GPU_WSPAWN_BITS  = $bits(gpu_wspawn_t);
   localparam int GPU_BARRIER_BITS = $bits(gpu_barrier_t);

   // One barrier slot: number of warps already waiting and which ones.
   typedef struct packed {
      logic [NW_W-1:0]      count;
      logic [NUM_WARPS-1:0] mask;
   } barrier_entry_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SPAWN = 1'b1
   } warp_ctl_state_e;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [NW_W-1:0] lowest_set(input logic [NUM_WARPS-1:0] m);
      logic [NW_W-1:0] idx;
      idx = '0;
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
         if (m[i]) idx = NW_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/vx_warp_ctl_barrier_table.sv
// Barrier table: per-id arrival count and wait mask. An arrival either
// joins the wait set or, when it completes the group, releases it.
module vx_warp_ctl_barrier_table
   import vx_warp_ctl_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 arrive_i,
   input  logic [NB_W-1:0]      id_i,
   input  logic [NW_W-1:0]      size_m1_i,
   input  logic [NW_W-1:0]      wid_i,
   output logic [NUM_WARPS-1:0] release_mask_o,
   output logic                 stall_o
);

   barrier_entry_t table_q [NUM_BARRIERS];
   barrier_entry_t entry_d;
   barrier_entry_t hit;

   assign hit = table_q[id_i];

   // Arrival logic for the addressed entry: release on the last arrival, else enlist.
   always_comb begin
      entry_d        = hit;
      release_mask_o = '0;
      stall_o        = 1'b0;
      if (arrive_i) begin
         if (hit.count == size_m1_i) begin
            entry_d        = '0;
            release_mask_o = hit.mask;
         end else begin
            entry_d.count         = hit.count + 1'b1;
            entry_d.mask[wid_i]   = 1'b1;
            stall_o               = 1'b1;
         end
      end
   end

   // Table storage; only the addressed entry changes, so other ids stay untouched.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_BARRIERS; i++) table_q[i] <= '0;
      end else if (arrive_i) begin
         table_q[id_i] <= entry_d;
      end
   end

endmodule

// File: rtl/vx_warp_ctl.sv
// Warp-control responder: applies tmc/wspawn/barrier requests to the
// active, thread and stall masks and sequences spawn starts to fetch.
module vx_warp_ctl
   import vx_warp_ctl_pkg::*;
(
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             req_valid_i,
   input  logic [NW_W-1:0]                  req_wid_i,
   input  logic [GPU_TMC_BITS-1:0]          req_tmc_i,
   input  logic [GPU_WSPAWN_BITS-1:0]       req_wspawn_i,
   input  logic [GPU_BARRIER_BITS-1:0]      req_barrier_i,
   output logic                             req_ready_o,
   output logic [NUM_WARPS-1:0]             active_warps_o,
   output logic [NUM_WARPS-1:0]             stalled_warps_o,
   output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks_o,
   output logic                             start_valid_o,
   input  logic                             start_ready_i,
   output logic [NW_W-1:0]                  start_wid_o,
   output logic [31:0]                      start_pc_o
);

   gpu_tmc_t        tmc;
   gpu_wspawn_t     wspawn;
   gpu_barrier_t    bar;

   warp_ctl_state_e      state_q, state_d;
   logic [NUM_WARPS-1:0] active_q, active_d;
   logic [NUM_WARPS-1:0] stalled_q, stalled_d;
   logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
   logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
   logic [NUM_WARPS-1:0] spawn_mask_q, spawn_mask_d;
   logic [31:0]          spawn_pc_q, spawn_pc_d;
   logic                 start_valid_q, start_valid_d;
   logic [NW_W-1:0]      start_wid_q, start_wid_d;

   logic                 req_fire;
   logic                 do_tmc;
   logic                 do_wspawn;
   logic                 do_bar;
   logic                 start_fire;
   logic [NUM_WARPS-1:0] release_mask;
   logic                 bar_stall;
   logic [NUM_WARPS-1:0] spawn_first;
   logic [NUM_WARPS-1:0] spawn_rest;

   assign tmc    = gpu_tmc_t'(req_tmc_i);
   assign wspawn = gpu_wspawn_t'(req_wspawn_i);
   assign bar    = gpu_barrier_t'(req_barrier_i);

   // Requests are only taken in IDLE; payloads are mutually exclusive, tmc first.
   assign req_fire   = req_valid_i && (state_q == ST_IDLE);
   assign do_tmc     = req_fire && tmc.valid;
   assign do_wspawn  = req_fire && !tmc.valid && wspawn.valid;
   assign do_bar     = req_fire && !tmc.valid && !wspawn.valid && bar.valid;
   assign start_fire = start_valid_q && start_ready_i;

   // The issuing warp never spawns itself.
   assign spawn_first = wspawn.wmask & ~(NUM_WARPS'(1) << req_wid_i);
   assign spawn_rest  = spawn_mask_q & ~(NUM_WARPS'(1) << start_wid_q);

   vx_warp_ctl_barrier_table u_barrier_table (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .arrive_i       (do_bar),
      .id_i           (bar.id),
      .size_m1_i      (bar.size_m1),
      .wid_i          (req_wid_i),
      .release_mask_o (release_mask),
      .stall_o        (bar_stall)
   );

   // Spawn FSM: latch the mask, hand out one start per handshake, then one
   // trailing cycle with an empty mask before returning to IDLE.
   always_comb begin
      state_d       = state_q;
      spawn_mask_d  = spawn_mask_q;
      spawn_pc_d    = spawn_pc_q;
      start_valid_d = start_valid_q;
      start_wid_d   = start_wid_q;
      case (state_q)
         ST_IDLE: begin
            if (do_wspawn) begin
               state_d       = ST_SPAWN;
               spawn_mask_d  = spawn_first;
               spawn_pc_d    = wspawn.pc;
               start_valid_d = |spawn_first;
               start_wid_d   = lowest_set(spawn_first);
            end
         end
         ST_SPAWN: begin
            if (spawn_mask_q == '0) begin
               state_d       = ST_IDLE;
               start_valid_d = 1'b0;
            end else if (start_fire) begin
               spawn_mask_d  = spawn_rest;
               start_valid_d = |spawn_rest;
               if (spawn_rest != '0) start_wid_d = lowest_set(spawn_rest);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Warp state updates from tmc, barrier arrivals and spawn handshakes.
   always_comb begin
      active_d  = active_q;
      tmask_d   = tmask_q;
      stalled_d = stalled_q & ~release_mask;
      if (do_tmc) begin
         tmask_d[req_wid_i] = tmc.tmask;
         if (tmc.tmask == '0) active_d[req_wid_i] = 1'b0;
      end
      if (bar_stall) stalled_d[req_wid_i] = 1'b1;
      if (start_fire) begin
         active_d[start_wid_q] = 1'b1;
         tmask_d[start_wid_q]  = NUM_THREADS'(1);
      end
   end

   // State registers; reset leaves only warp 0 running with thread 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         active_q      <= NUM_WARPS'(1);
         stalled_q     <= '0;
         for (int i = 0; i < NUM_WARPS; i++) tmask_q[i] <= '0;
         tmask_q[0]    <= NUM_THREADS'(1);
         spawn_mask_q  <= '0;
         spawn_pc_q    <= '0;
         start_valid_q <= 1'b0;
         start_wid_q   <= '0;
      end else begin
         state_q       <= state_d;
         active_q      <= active_d;
         stalled_q     <= stalled_d;
         tmask_q       <= tmask_d;
         spawn_mask_q  <= spawn_mask_d;
         spawn_pc_q    <= spawn_pc_d;
         start_valid_q <= start_valid_d;
         start_wid_q   <= start_wid_d;
      end
   end

   assign req_ready_o     = (state_q == ST_IDLE);
   assign active_warps_o  = active_q;
   assign stalled_warps_o = stalled_q;
   assign start_valid_o   = start_valid_q;
   assign start_wid_o     = start_wid_q;
   assign start_pc_o      = spawn_pc_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARPS; gi++) begin : g_tmask_out
         assign thread_masks_o[gi*NUM_THREADS +: NUM_THREADS] = tmask_q[gi];
      end
   endgenerate

endmodule
